// File: rtl/arcade_input_mapper_pkg.sv
// Shared types and helpers for the arcade input mapper.
//   BTN_IDX_W  : width of a logical button index
//   BTN_NONE   : button index meaning "not mapped to any button"
//   key_code_t : {ext, scan} PS/2 key code
//   key_match  : keymap entry comparison with optional ext-bit wildcard
//   btn_hit    : true when a mapped index selects logical button b
package arcade_input_pkg;

    localparam int BTN_IDX_W = 5;

    typedef logic [BTN_IDX_W-1:0] btn_idx_t;
    typedef logic [8:0]           key_code_t;

    localparam btn_idx_t BTN_NONE = 5'h1F;

    function automatic logic key_match(key_code_t code, key_code_t entry, logic wild);
        return (code[7:0] == entry[7:0]) && ((code[8] == entry[8]) || wild);
    endfunction

    function automatic logic btn_hit(btn_idx_t idx, int b);
        return (idx != BTN_NONE) && (int'(idx) == b);
    endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Bundle between the host side (hps_io) and the mapper.
//   ps2_key    : [10]=toggle strobe, [9]=pressed, [8:0]={ext,scan}
//   joystick_0 : player-1 joystick bits
//   joystick_1 : player-2 joystick bits
//   cocktail   : 0 = merge everything onto player 1, 1 = split per player
//   af_mask    : buttons subject to autofire
//   af_en      : global autofire enable
//   btn_p1/p2  : registered, active-high logical buttons per player
// master = host side driving inputs, slave = the mapper.
interface arcade_input_mapper_if #(
    parameter int NUM_BTN = 16
);
    logic [10:0]        ps2_key;
    logic [15:0]        joystick_0;
    logic [15:0]        joystick_1;
    logic               cocktail;
    logic [NUM_BTN-1:0] af_mask;
    logic               af_en;
    logic [NUM_BTN-1:0] btn_p1;
    logic [NUM_BTN-1:0] btn_p2;

    modport master (
        output ps2_key, joystick_0, joystick_1, cocktail, af_mask, af_en,
        input  btn_p1, btn_p2
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, cocktail, af_mask, af_en,
        output btn_p1, btn_p2
    );
endinterface

// File: rtl/arcade_input_mapper_pulse.sv
// arcade_pulse_stretch: guarantees a minimum high time for a level input.
// A rising edge of raw_i loads a down counter with CYCLES-1; the output is
// raw_i OR (counter != 0), so a one-cycle pulse is seen for CYCLES cycles
// after the output register, and a held input stays high indefinitely.
//   clk_sys : clock
//   reset_n : synchronous reset, active low
//   raw_i   : level input
//   out_o   : stretched level (combinational; register downstream)
module arcade_pulse_stretch #(
    parameter int CYCLES = 240000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw_i,
    output logic out_o
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw_q;

    // NOTE: every variable an always_comb writes gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (raw_i && !raw_q) begin
            cnt_d = CNT_W'(CYCLES - 1);     // re-edge while counting reloads
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt_q <= '0;
            raw_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            raw_q <= raw_i;
        end
    end

    assign out_o = raw_i || (cnt_q != '0);
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: keyboard/joystick to cabinet-button mapper.
// Tracks press state per keymap entry, ORs keys and joystick bits onto
// NUM_BTN logical buttons per player, routes players for upright/cocktail,
// stretches coin pulses and applies autofire. All outputs are registered.
//   clk_sys : system clock
//   reset_n : synchronous reset, active low
//   io      : arcade_input_mapper_if.slave (inputs and btn_p1/btn_p2)
// COIN_BTN must be below NUM_BTN.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int                    NUM_BTN     = 16,
    parameter int                    NUM_KEYS    = 16,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES   = '0,
    parameter logic [NUM_KEYS-1:0]   KEY_WILD    = '0,
    parameter logic [5*NUM_KEYS-1:0] KEY_BTN     = '1,
    parameter logic [NUM_KEYS-1:0]   KEY_PLAYER  = '0,
    parameter logic [79:0]           JOY_MAP     = '1,
    parameter int                    COIN_BTN    = 9,
    parameter int                    COIN_CYCLES = 240000,
    parameter int                    AF_DIV      = 800000
) (
    input logic                   clk_sys,
    input logic                   reset_n,
    arcade_input_mapper_if.slave  io
);
    localparam int AF_W = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;

    logic                toggle_q;
    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_BTN-1:0]  own_p1, own_p2, raw_p1, raw_p2, af_gate;
    logic [NUM_BTN-1:0]  btn_p1_q, btn_p1_d, btn_p2_q, btn_p2_d;
    logic [AF_W-1:0]     af_cnt_q, af_cnt_d;
    logic                af_phase_q, af_phase_d;
    logic                coin_p1, coin_p2;

    // Key events: every entry matching the code takes the pressed bit.
    always_comb begin
        key_state_d = key_state_q;
        if (io.ps2_key[10] != toggle_q) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_match(io.ps2_key[8:0], KEY_CODES[9*i +: 9], KEY_WILD[i])) begin
                    key_state_d[i] = io.ps2_key[9];
                end
            end
        end
    end

    // Merge sources onto logical buttons; unmapped indices never hit.
    always_comb begin
        own_p1 = '0;
        own_p2 = '0;
        for (int b = 0; b < NUM_BTN; b++) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (btn_hit(KEY_BTN[5*i +: 5], b)) begin
                    if (KEY_PLAYER[i]) own_p2[b] = own_p2[b] | key_state_q[i];
                    else               own_p1[b] = own_p1[b] | key_state_q[i];
                end
            end
            for (int j = 0; j < 16; j++) begin
                if (btn_hit(JOY_MAP[5*j +: 5], b)) begin
                    own_p1[b] = own_p1[b] | io.joystick_0[j];
                    own_p2[b] = own_p2[b] | io.joystick_1[j];
                end
            end
        end
    end

    // Upright cabinets fold player 2 onto player 1.
    assign raw_p1 = io.cocktail ? own_p1 : (own_p1 | own_p2);
    assign raw_p2 = io.cocktail ? own_p2 : '0;

    arcade_pulse_stretch #(.CYCLES(COIN_CYCLES)) u_coin_p1 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw_i   (raw_p1[COIN_BTN]),
        .out_o   (coin_p1)
    );

    arcade_pulse_stretch #(.CYCLES(COIN_CYCLES)) u_coin_p2 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw_i   (raw_p2[COIN_BTN]),
        .out_o   (coin_p2)
    );

    // Autofire divider: phase flips each time the counter wraps.
    always_comb begin
        af_cnt_d   = af_cnt_q + 1'b1;
        af_phase_d = af_phase_q;
        if (af_cnt_q == AF_W'(AF_DIV - 1)) begin
            af_cnt_d   = '0;
            af_phase_d = ~af_phase_q;
        end
    end

    // Autofired buttons are masked off during phase 0; the coin button takes
    // the stretched level instead so autofire can never chop a coin pulse.
    always_comb begin
        af_gate  = io.af_en ? io.af_mask : '0;
        btn_p1_d = raw_p1 & ~(af_gate & {NUM_BTN{~af_phase_q}});
        btn_p2_d = raw_p2 & ~(af_gate & {NUM_BTN{~af_phase_q}});
        btn_p1_d[COIN_BTN] = coin_p1;
        btn_p2_d[COIN_BTN] = coin_p2;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            // Loading the live strobe means a toggle left over from before
            // reset is not replayed as a key event.
            toggle_q    <= io.ps2_key[10];
            key_state_q <= '0;
            af_cnt_q    <= '0;
            af_phase_q  <= 1'b0;
            btn_p1_q    <= '0;
            btn_p2_q    <= '0;
        end else begin
            toggle_q    <= io.ps2_key[10];
            key_state_q <= key_state_d;
            af_cnt_q    <= af_cnt_d;
            af_phase_q  <= af_phase_d;
            btn_p1_q    <= btn_p1_d;
            btn_p2_q    <= btn_p2_d;
        end
    end

    assign io.btn_p1 = btn_p1_q;
    assign io.btn_p2 = btn_p2_q;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: directed scenarios followed by
// randomized traffic, each cycle compared against a behavioural model.
module tb_arcade_input_mapper;
    localparam int NB          = 16;
    localparam int NK          = 6;
    localparam int COIN        = 9;
    localparam int COIN_CYCLES = 8;
    localparam int AF_DIV      = 4;

    // Keymap: 0 wild 'h75->3, 'h6B and 'h74 share 0, 'h7D strict->4,
    // 'h1C player 2 -> 6, 'h1B unmapped.
    localparam logic [9*NK-1:0] KEY_CODES  = {9'h01B, 9'h01C, 9'h07D, 9'h074, 9'h06B, 9'h075};
    localparam logic [NK-1:0]   KEY_WILD   = 6'b000001;
    localparam logic [5*NK-1:0] KEY_BTN    = {5'd31, 5'd6, 5'd4, 5'd0, 5'd0, 5'd3};
    localparam logic [NK-1:0]   KEY_PLAYER = 6'b010000;
    localparam logic [79:0]     JOY_MAP    = {5'd0, 5'd20, 5'd8, 5'd7, 5'd15, 5'd14, 5'd9, 5'd31,
                                              5'd1, 5'd1, 5'd2, 5'd5, 5'd13, 5'd12, 5'd11, 5'd10};

    logic clk_sys = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    arcade_input_mapper_if #(.NUM_BTN(NB)) io ();

    arcade_input_mapper #(
        .NUM_BTN     (NB),
        .NUM_KEYS    (NK),
        .KEY_CODES   (KEY_CODES),
        .KEY_WILD    (KEY_WILD),
        .KEY_BTN     (KEY_BTN),
        .KEY_PLAYER  (KEY_PLAYER),
        .JOY_MAP     (JOY_MAP),
        .COIN_BTN    (COIN),
        .COIN_CYCLES (COIN_CYCLES),
        .AF_DIV      (AF_DIV)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .io      (io)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- reference model ----------------
    logic [NK-1:0] m_keys;
    logic          m_tog;
    int            m_n;           // clock edges since reset released
    int            m_rise1, m_rise2;
    logic          m_prev1, m_prev2;
    logic [NB-1:0] exp_p1, exp_p2;

    task automatic model_step();
        logic [NB-1:0] own0, own1, r1, r2;
        logic          ph;
        if (!reset_n) begin
            m_keys  = '0;
            m_tog   = io.ps2_key[10];
            m_n     = 0;
            m_rise1 = -1000000;
            m_rise2 = -1000000;
            m_prev1 = 1'b0;
            m_prev2 = 1'b0;
            exp_p1  = '0;
            exp_p2  = '0;
            return;
        end
        own0 = '0;
        own1 = '0;
        for (int i = 0; i < NK; i++) begin
            int b = int'(KEY_BTN[5*i +: 5]);
            if (m_keys[i] && b < NB) begin
                if (KEY_PLAYER[i]) own1 |= NB'(1) << b;
                else               own0 |= NB'(1) << b;
            end
        end
        for (int j = 0; j < 16; j++) begin
            int b = int'(JOY_MAP[5*j +: 5]);
            if (b < NB) begin
                if (io.joystick_0[j]) own0 |= NB'(1) << b;
                if (io.joystick_1[j]) own1 |= NB'(1) << b;
            end
        end
        r1 = io.cocktail ? own0 : (own0 | own1);
        r2 = io.cocktail ? own1 : '0;
        // Autofire phase is high on every odd block of AF_DIV cycles.
        ph = ((m_n / AF_DIV) % 2) == 1;
        for (int b = 0; b < NB; b++) begin
            logic fire_off;
            fire_off  = io.af_en && io.af_mask[b] && !ph;
            exp_p1[b] = r1[b] && !fire_off;
            exp_p2[b] = r2[b] && !fire_off;
        end
        // Coin: high while raw, or within COIN_CYCLES edges of the last rise.
        if (r1[COIN] && !m_prev1) m_rise1 = m_n;
        if (r2[COIN] && !m_prev2) m_rise2 = m_n;
        m_prev1 = r1[COIN];
        m_prev2 = r2[COIN];
        exp_p1[COIN] = r1[COIN] || (m_n - m_rise1 < COIN_CYCLES);
        exp_p2[COIN] = r2[COIN] || (m_n - m_rise2 < COIN_CYCLES);
        // Key event takes effect for the next edge.
        if (io.ps2_key[10] != m_tog) begin
            for (int i = 0; i < NK; i++) begin
                logic [8:0] e;
                e = KEY_CODES[9*i +: 9];
                if (io.ps2_key[7:0] == e[7:0] && (io.ps2_key[8] == e[8] || KEY_WILD[i]))
                    m_keys[i] = io.ps2_key[9];
            end
        end
        m_tog = io.ps2_key[10];
        m_n++;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        check("model_p1", 32'(io.btn_p1), 32'(exp_p1));
        check("model_p2", 32'(io.btn_p2), 32'(exp_p2));
    endtask

    task automatic send_key(input logic [8:0] code, input logic pressed);
        io.ps2_key = {~io.ps2_key[10], pressed, code};
        tick();
    endtask

    // ---------------- stimulus ----------------
    int high;

    initial begin
        // T1: toggle high and a pressed code held through reset.
        reset_n       = 1'b0;
        io.ps2_key    = {1'b1, 1'b1, 9'h06B};
        io.joystick_0 = '0;
        io.joystick_1 = '0;
        io.cocktail   = 1'b0;
        io.af_mask    = '0;
        io.af_en      = 1'b0;
        repeat (3) tick();
        check("t1_reset_p1", 32'(io.btn_p1), 32'h0);
        check("t1_reset_p2", 32'(io.btn_p2), 32'h0);
        reset_n = 1'b1;
        repeat (3) tick();
        check("t1_no_event", 32'(io.btn_p1), 32'h0);

        // T2: wildcard entry and strict ext matching.
        send_key(9'h175, 1'b1);
        check("t2_lat1", 32'(io.btn_p1[3]), 32'h0);
        tick();
        check("t2_wild_press", 32'(io.btn_p1[3]), 32'h1);
        send_key(9'h075, 1'b0);
        tick();
        check("t2_wild_release", 32'(io.btn_p1[3]), 32'h0);
        send_key(9'h17D, 1'b1);
        tick();
        check("t2_strict_ext", 32'(io.btn_p1[4]), 32'h0);
        send_key(9'h07D, 1'b1);
        tick();
        check("t2_strict_hit", 32'(io.btn_p1[4]), 32'h1);
        send_key(9'h07D, 1'b0);

        // T3: two keys on one button.
        send_key(9'h06B, 1'b1);
        send_key(9'h074, 1'b1);
        tick();
        check("t3_both", 32'(io.btn_p1[0]), 32'h1);
        send_key(9'h06B, 1'b0);
        tick();
        check("t3_one_left", 32'(io.btn_p1[0]), 32'h1);
        send_key(9'h074, 1'b0);
        tick();
        check("t3_none", 32'(io.btn_p1[0]), 32'h0);

        // T4: cocktail routing of joystick_1.
        io.joystick_1[5] = 1'b1;
        tick();
        check("t4_upright_p1", 32'(io.btn_p1[2]), 32'h1);
        check("t4_upright_p2", 32'(io.btn_p2), 32'h0);
        io.cocktail = 1'b1;
        tick();
        check("t4_cocktail_p2", 32'(io.btn_p2[2]), 32'h1);
        check("t4_cocktail_p1", 32'(io.btn_p1[2]), 32'h0);
        io.joystick_1 = '0;
        io.cocktail   = 1'b0;
        tick();

        // T5: coin stretching, single pulse then re-edge at cycle 4.
        io.joystick_0[9] = 1'b1;
        tick();
        high = int'(io.btn_p1[9]);
        io.joystick_0[9] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            high += int'(io.btn_p1[9]);
        end
        check("t5_single", 32'(high), 32'd8);
        io.joystick_0[9] = 1'b1;
        tick();
        high = int'(io.btn_p1[9]);
        io.joystick_0[9] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            high += int'(io.btn_p1[9]);
        end
        io.joystick_0[9] = 1'b1;
        tick();
        high += int'(io.btn_p1[9]);
        io.joystick_0[9] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            high += int'(io.btn_p1[9]);
        end
        check("t5_reedge", 32'(high), 32'd12);

        // T6: autofire on button 5 (joystick_0 bit 4).
        io.af_mask       = 16'h0020;
        io.af_en         = 1'b1;
        io.joystick_0[4] = 1'b1;
        high = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            high += int'(io.btn_p1[5]);
        end
        check("t6_duty", 32'(high), 32'd8);
        io.af_en = 1'b0;
        tick();
        check("t6_af_off_a", 32'(io.btn_p1[5]), 32'h1);
        tick();
        check("t6_af_off_b", 32'(io.btn_p1[5]), 32'h1);
        io.af_en = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        check("t6_reset_p1", 32'(io.btn_p1), 32'h0);
        check("t6_reset_p2", 32'(io.btn_p2), 32'h0);
        reset_n          = 1'b1;
        io.joystick_0    = '0;
        io.af_en         = 1'b0;
        io.af_mask       = '0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 15) begin
                logic [8:0] code;
                int         sel;
                sel = int'($urandom_range(0, NK + 1));
                if (sel < NK) begin
                    code = KEY_CODES[9*sel +: 9];
                    if ($urandom_range(0, 3) == 0) code[8] = ~code[8];
                end else begin
                    code = 9'($urandom);
                end
                io.ps2_key = {~io.ps2_key[10], 1'($urandom), code};
            end
            if ($urandom_range(0, 7) == 0) io.joystick_0 = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) io.joystick_1 = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) io.cocktail = ~io.cocktail;
            if ($urandom_range(0, 127) == 0) begin
                io.af_en   = 1'($urandom);
                io.af_mask = 16'($urandom);
            end
            reset_n = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
